hazard_fwd_unit: RTL
====================

# hazard_fwd_unit

Parametrised hazard and forwarding unit for the RISC RNS pipeline, generalising the fixed two-point forwarding path to a configurable number of in-flight stages and residue domains. It tracks every issued instruction from EX through writeback and selects forwarded operands for the instruction leaving ID. It detects load-use hazards and raises a one-cycle stall, and squashes the ID instruction on a taken branch. It also drives the register-file write port and keeps a saturating forwarding-event counter.

## Interface
- NUM_DOMAINS, 1, residue domains; data width DW = NUM_DOMAINS*8
- REG_ADDR_WID, 3, register address width
- FWD_DEPTH, 3, tracked stages (0 = EX, 1 = MEM, FWD_DEPTH-1 = WB); legal range ≥3

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- id_valid  in  1  instruction present in ID
- id_src1_addr, id_src2_addr  in  REG_ADDR_WID  source registers
- id_rd_data1, id_rd_data2  in  DW  register-file read data
- id_dst_addr  in  REG_ADDR_WID  destination register
- id_reg_wr  in  1  instruction writes a register
- id_is_load  in  1  instruction is a load
- ex_result  in  DW  ALU result of the stage-0 instruction
- mem_dout  in  DW  load data of the stage-1 instruction
- branch_taken_EX  in  1  flush ID instruction
- op1_fwd, op2_fwd  out  DW  resolved operands for the ID instruction
- stall  out  1  load-use hazard; ID must hold
- wb_wr_en  out  1  register-file write enable
- wb_addr  out  REG_ADDR_WID  register-file write address
- wb_data  out  DW  register-file write data
- fwd_hit_cnt  out  16  saturating count of forwarded operands

## Operation
- Each stage entry holds: valid, reg_wr, is_load, dst, data (DW). Entries shift 0→1→…→FWD_DEPTH-1 every cycle. The unit has no downstream backpressure.
- Stage data source:
  - Stage 0 is ex_result. It is usable only if is_load=0.
  - Stage 1 is mem_dout if is_load=1, otherwise the stored data.
  - Stage 2 and later use the stored data.
- The shift captures the stage-0 ALU result and the stage-1 load data.
- Match for operand n: the entry has valid & reg_wr and dst == id_srcn_addr. The lowest stage index (youngest) wins. Every address, including 0, is an ordinary register.
- Operand selection:
  - No match: opn_fwd = id_rd_datan.
  - Otherwise opn_fwd = the winning entry's data.
  - Both operands resolve independently, including when src1 == src2.
- Hazard: stall = id_valid & !branch_taken_EX & (the winning match for either operand is a stage-0 load).
- Stage 0 next state:
  - id_valid & !stall & !branch_taken_EX: load the ID instruction.
  - Otherwise: a bubble (valid=0).
- Flush: branch_taken_EX overrides stall. The squashed instruction never reaches WB.
- Writeback: wb_wr_en = valid & reg_wr of stage FWD_DEPTH-1. wb_addr and wb_data come from that entry.
- Counter: on each accepted issue, fwd_hit_cnt adds the number of forwarded operands (0, 1 or 2). The count saturates at 0xFFFF.
- Data is forwarded as a whole DW vector. The unit performs no per-domain arithmetic.

## Timing
- Reset (reset=0) asynchronously clears:
  - all entry valid bits, data and dst, and fwd_hit_cnt to 0
  - therefore wb_wr_en=0, wb_addr=0, wb_data=0
  - stall=0, and opn_fwd = id_rd_datan
- Normal operation resumes on the first rising edge after reset returns to 1.
- Accepted at edge k:
  - the instruction occupies stage s during cycle k+s
  - it writes back during cycle k+FWD_DEPTH-1
- op1_fwd, op2_fwd and stall are combinational from the ID inputs and the current entries (same cycle).
- A load-use pair stalls exactly 1 cycle. On the next cycle the load is in stage 1 and mem_dout is forwarded.
- A WB-stage entry is forwarded in the same cycle it writes, so the register file needs no write-through.
- Reset asserted mid-operation discards all in-flight entries. No partial writeback occurs.

## Test plan
- ALU chain (NUM_DOMAINS=1, FWD_DEPTH=3): issue write r3 with ex_result=0x2A, next cycle issue src1=r3 -> op1_fwd=0x2A, stall=0, fwd_hit_cnt=1.
- Load-use: issue load r2, next cycle src2=r2 -> stall=1 for one cycle. The following cycle, with mem_dout=0x55 -> op2_fwd=0x55 and stall=0.
- Priority: consecutive writes r1=0x11 then r1=0x22, then read src1=src2=r1 -> both operands 0x22, fwd_hit_cnt +2.
- Flush: branch_taken_EX=1 while ID holds load r4 and a hazard exists -> stall=0. The next instruction reading r4 gets id_rd_data, and wb_wr_en never asserts with wb_addr=4.
- Writeback/width (NUM_DOMAINS=3): issue r5 with ex_result=0x7E1203 at edge k -> wb_wr_en=1, wb_addr=5, wb_data=0x7E1203 during cycle k+2 only.
- Async reset and saturation:
  - drive reset=0 between edges with three valid entries -> wb_wr_en=0 and fwd_hit_cnt=0 before the next edge
  - preload the count near 0xFFFF and issue double hits -> the count holds at 0xFFFF

Source files
------------

// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if: ID-stage, EX/MEM result and writeback signals of the hazard/forwarding unit
interface hazard_fwd_unit_if #(
  parameter int NUM_DOMAINS = 1,
  parameter int REG_ADDR_WID = 3
);
  localparam int DW = NUM_DOMAINS * 8;
  logic                    id_valid;
  logic [REG_ADDR_WID-1:0] id_src1_addr, id_src2_addr, id_dst_addr;
  logic [DW-1:0]           id_rd_data1, id_rd_data2;
  logic                    id_reg_wr, id_is_load;
  logic [DW-1:0]           ex_result, mem_dout;
  logic                    branch_taken_EX;
  logic [DW-1:0]           op1_fwd, op2_fwd;
  logic                    stall;
  logic                    wb_wr_en;
  logic [REG_ADDR_WID-1:0] wb_addr;
  logic [DW-1:0]           wb_data;
  logic [15:0]             fwd_hit_cnt;
  modport master (
    output id_valid, id_src1_addr, id_src2_addr, id_dst_addr, id_rd_data1, id_rd_data2,
           id_reg_wr, id_is_load, ex_result, mem_dout, branch_taken_EX,
    input  op1_fwd, op2_fwd, stall, wb_wr_en, wb_addr, wb_data, fwd_hit_cnt
  );
  modport slave (
    input  id_valid, id_src1_addr, id_src2_addr, id_dst_addr, id_rd_data1, id_rd_data2,
           id_reg_wr, id_is_load, ex_result, mem_dout, branch_taken_EX,
    output op1_fwd, op2_fwd, stall, wb_wr_en, wb_addr, wb_data, fwd_hit_cnt
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: operand forwarding, load-use stall, branch squash and writeback
// across FWD_DEPTH tracked stages (0 = EX, 1 = MEM, last = WB).
module hazard_fwd_unit #(
  parameter int NUM_DOMAINS = 1,
  parameter int REG_ADDR_WID = 3,
  parameter int FWD_DEPTH = 3
) (
  input logic clk,
  input logic reset,
  hazard_fwd_unit_if.slave b
);
  localparam int DW = NUM_DOMAINS * 8;
  localparam int L = FWD_DEPTH - 1;
  logic [L:0]              vld_q, vld_d, wr_q, wr_d;
  logic [1:0]              ld_q, ld_d;
  logic [REG_ADDR_WID-1:0] dst_q [FWD_DEPTH];
  logic [REG_ADDR_WID-1:0] dst_d [FWD_DEPTH];
  logic [DW-1:0]           dat_q [1:L];
  logic [DW-1:0]           dat_d [1:L];
  logic [DW-1:0]           sd [FWD_DEPTH];
  logic [15:0]             cnt_q, cnt_d;
  logic [16:0]             sum;
  logic                    hit1, hit2, lu1, lu2, accept;

  // Stage 0 has no stored data: its value is the live ALU result.
  always_comb begin
    sd[0] = b.ex_result;
    sd[1] = ld_q[1] ? b.mem_dout : dat_q[1];
    for (int s = 2; s < FWD_DEPTH; s++) sd[s] = dat_q[s];
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    b.op1_fwd = b.id_rd_data1;
    b.op2_fwd = b.id_rd_data2;
    hit1 = 1'b0;
    hit2 = 1'b0;
    lu1 = 1'b0;
    lu2 = 1'b0;
    for (int s = L; s >= 0; s--) begin
      if (vld_q[s] && wr_q[s] && dst_q[s] == b.id_src1_addr) begin
        b.op1_fwd = sd[s];
        hit1 = 1'b1;
        lu1 = (s == 0) && ld_q[0];
      end
      if (vld_q[s] && wr_q[s] && dst_q[s] == b.id_src2_addr) begin
        b.op2_fwd = sd[s];
        hit2 = 1'b1;
        lu2 = (s == 0) && ld_q[0];
      end
    end
  end

  assign b.stall = b.id_valid && !b.branch_taken_EX && (lu1 || lu2);
  assign accept = b.id_valid && !b.stall && !b.branch_taken_EX;
  assign sum = {1'b0, cnt_q} + 17'(hit1) + 17'(hit2);
  assign cnt_d = accept ? (sum[16] ? 16'hFFFF : sum[15:0]) : cnt_q;

  always_comb begin
    vld_d = {vld_q[L-1:0], accept};
    wr_d = {wr_q[L-1:0], b.id_reg_wr};
    ld_d = {ld_q[0], b.id_is_load};
    dst_d[0] = b.id_dst_addr;
    for (int s = 1; s < FWD_DEPTH; s++) begin
      dst_d[s] = dst_q[s-1];
      dat_d[s] = sd[s-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      wr_q <= '0;
      ld_q <= '0;
      cnt_q <= '0;
      for (int s = 0; s < FWD_DEPTH; s++) dst_q[s] <= '0;
      for (int s = 1; s < FWD_DEPTH; s++) dat_q[s] <= '0;
    end else begin
      vld_q <= vld_d;
      wr_q <= wr_d;
      ld_q <= ld_d;
      cnt_q <= cnt_d;
      dst_q <= dst_d;
      dat_q <= dat_d;
    end
  end

  assign b.wb_wr_en = vld_q[L] && wr_q[L];
  assign b.wb_addr = dst_q[L];
  assign b.wb_data = dat_q[L];
  assign b.fwd_hit_cnt = cnt_q;
endmodule
